// File: rtl/mmio_bus_ctrl_if.sv
// MMIO controller bus bundle: CPU request/response and device strobes.
// slave = controller view, master = CPU/device-aggregator view.
interface mmio_bus_ctrl_if;
   logic        req_valid;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_ready;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;
   logic        mmio_read;
   logic        mmio_write;
   logic [31:0] mmio_addr;
   logic [31:0] mmio_write_data;
   logic        mmio_done;
   logic [31:0] mmio_read_data;
   logic [31:0] err_addr;

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata,
      input  mmio_done, mmio_read_data,
      output req_ready, resp_valid, resp_err, resp_rdata,
      output mmio_read, mmio_write, mmio_addr, mmio_write_data,
      output err_addr
   );

   modport master (
      output req_valid, req_write, req_addr, req_wdata,
      output mmio_done, mmio_read_data,
      input  req_ready, resp_valid, resp_err, resp_rdata,
      input  mmio_read, mmio_write, mmio_addr, mmio_write_data,
      input  err_addr
   );
endinterface

// File: rtl/mmio_bus_ctrl.sv
// MMIO request controller: one request at a time, checks, strobes,
// timeout guard and a one-cycle response pulse.
module mmio_bus_ctrl #(
   parameter logic [31:0] MMIO_BASE      = 32'hFFFF_0000,
   parameter logic [31:0] MMIO_MASK      = 32'hFFFF_0000,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic           sys_clk,
   input  logic           rst,
   mmio_bus_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

   state_t      state, state_n;
   logic        rd_q, rd_d, wr_q, wr_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
   logic        rv_q, rv_d, rerr_q, rerr_d;
   logic [31:0] rdata_q, rdata_d, eaddr_q, eaddr_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        bad_req;

   assign bad_req = (bus.req_addr[1:0] != 2'b00) ||
                    ((bus.req_addr & MMIO_MASK) != MMIO_BASE);

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rv_q    <= 1'b0;
         rerr_q  <= 1'b0;
         rdata_q <= '0;
         eaddr_q <= '0;
         cnt_q   <= '0;
      end else begin
         state   <= state_n;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rv_q    <= rv_d;
         rerr_q  <= rerr_d;
         rdata_q <= rdata_d;
         eaddr_q <= eaddr_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE: begin
            if (bus.req_valid)
               state_n = bad_req ? RESP : BUSY;
         end
         BUSY: begin
            if (bus.mmio_done || cnt_q == LAST_CNT)
               state_n = RESP;
         end
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Next values for the registered outputs; response fields default to 0
   // so they only live for the single RESP cycle.
   always_comb begin
      rd_d    = rd_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rv_d    = 1'b0;
      rerr_d  = 1'b0;
      rdata_d = '0;
      eaddr_d = eaddr_q;
      cnt_d   = cnt_q;
      case (state)
         IDLE: begin
            if (bus.req_valid) begin
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               if (bad_req) begin
                  rv_d    = 1'b1;
                  rerr_d  = 1'b1;
                  eaddr_d = bus.req_addr;
               end else begin
                  rd_d  = ~bus.req_write;
                  wr_d  = bus.req_write;
                  cnt_d = '0;
               end
            end
         end
         BUSY: begin
            // done takes priority over an expiring timeout
            if (bus.mmio_done) begin
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               rv_d    = 1'b1;
               rdata_d = rd_q ? bus.mmio_read_data : 32'h0;
            end else if (cnt_q == LAST_CNT) begin
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               rv_d    = 1'b1;
               rerr_d  = 1'b1;
               eaddr_d = addr_q;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: ;
      endcase
   end

   assign bus.req_ready       = (state == IDLE);
   assign bus.resp_valid      = rv_q;
   assign bus.resp_err        = rerr_q;
   assign bus.resp_rdata      = rdata_q;
   assign bus.mmio_read       = rd_q;
   assign bus.mmio_write      = wr_q;
   assign bus.mmio_addr       = addr_q;
   assign bus.mmio_write_data = wdata_q;
   assign bus.err_addr        = eaddr_q;
endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Scoreboard bench for mmio_bus_ctrl with a small delay-programmable
// device model; responses are checked by an independent monitor.
module tb_mmio_bus_ctrl;
   logic clk;
   logic rst;

   mmio_bus_ctrl_if b();

   mmio_bus_ctrl #(
      .MMIO_BASE(32'hFFFF_0000),
      .MMIO_MASK(32'hFFFF_0000),
      .TIMEOUT_CYCLES(4)
   ) dut (
      .sys_clk(clk),
      .rst(rst),
      .bus(b.slave)
   );

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      logic [31:0] eaddr;
   } exp_t;

   exp_t exp_q[$];

   int pass_cnt = 0;
   int total_cnt = 0;
   int dev_wait = -1;
   logic [31:0] dev_data = 32'h0;
   int bcnt = 0;
   int strobe_cnt = 0;
   int stab_bad = 0;
   int both_cnt = 0;
   bit tb_wr = 1'b0;
   logic [31:0] exp_addr = 32'h0;
   logic [31:0] exp_wdata = 32'h0;
   logic [31:0] last_err = 32'h0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string n, input logic [31:0] act,
                      input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", n, act, exp);
   endtask

   // Device model: raises done in strobe cycle dev_wait+1 (never if <0)
   always @(negedge clk) begin
      if (b.mmio_read || b.mmio_write) begin
         bcnt++;
         if (tb_wr ? b.mmio_write : b.mmio_read) strobe_cnt++;
         else stab_bad++;
         if (b.mmio_addr !== exp_addr || b.mmio_write_data !== exp_wdata)
            stab_bad++;
      end else begin
         bcnt = 0;
      end
      if (b.mmio_read && b.mmio_write) both_cnt++;
      b.mmio_done = (b.mmio_read || b.mmio_write) && dev_wait >= 0 &&
                    bcnt == dev_wait + 1;
      b.mmio_read_data = b.mmio_done ? dev_data : 32'h0;
   end

   // Response monitor / scoreboard
   always @(negedge clk) begin
      if (!rst && b.resp_valid) begin
         if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_resp: got err=%b rdata=%h expected none",
                     b.resp_err, b.resp_rdata);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("resp_err", 32'(b.resp_err), 32'(e.err));
            chk("resp_rdata", b.resp_rdata, e.rdata);
            chk("err_addr", b.err_addr, e.eaddr);
         end
      end
   end

   task automatic push_exp(input logic err, input logic [31:0] rd,
                           input logic [31:0] a);
      exp_t e;
      e.err = err;
      e.rdata = rd;
      if (err) last_err = a;
      e.eaddr = last_err;
      exp_q.push_back(e);
   endtask

   task automatic run_req(input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input int wt,
                          input logic [31:0] dd, input logic err,
                          input logic [31:0] rd, input int n_strobe,
                          input int exp_lat, input string tag);
      int lat;
      int guard;
      @(negedge clk);
      push_exp(err, rd, a);
      tb_wr = wr;
      exp_addr = a;
      exp_wdata = d;
      dev_wait = wt;
      dev_data = dd;
      strobe_cnt = 0;
      stab_bad = 0;
      guard = 0;
      while (!b.req_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      b.req_valid = 1'b1;
      b.req_write = wr;
      b.req_addr = a;
      b.req_wdata = d;
      @(posedge clk);
      #1 b.req_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!b.resp_valid && lat < 300);
      chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_strobes"}, 32'(strobe_cnt), 32'(n_strobe));
      chk({tag, "_stable"}, 32'(stab_bad), 32'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      rst = 1'b1;
      b.req_valid = 1'b0;
      b.req_write = 1'b0;
      b.req_addr = 32'h0;
      b.req_wdata = 32'h0;
      b.mmio_done = 1'b0;
      b.mmio_read_data = 32'h0;
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(b.req_ready), 32'd1);
      chk("rst_strobes", {30'd0, b.mmio_read, b.mmio_write}, 32'd0);
      chk("rst_addr", b.mmio_addr, 32'h0);
      chk("rst_resp", {31'd0, b.resp_valid}, 32'd0);
      chk("rst_err_addr", b.err_addr, 32'h0);
      rst = 1'b0;

      run_req(0, 32'hFFFF_0000, 32'h0, 0, 32'h00AB_CDEF,
              0, 32'h00AB_CDEF, 1, 2, "ld_zero_wait");
      run_req(1, 32'hFFFF_0010, 32'h0000_00FF, 3, 32'hDEAD_BEEF,
              0, 32'h0, 4, 5, "st_wait3");
      run_req(0, 32'hFFFF_0002, 32'h0, 0, 32'h1111_1111,
              1, 32'h0, 0, 1, "ld_misalign");
      run_req(0, 32'h0000_1000, 32'h0, 0, 32'h2222_2222,
              1, 32'h0, 0, 1, "ld_outwin");
      run_req(0, 32'hFFFF_0100, 32'h0, -1, 32'h0,
              1, 32'h0, 4, 5, "ld_timeout");
      run_req(0, 32'hFFFF_0100, 32'h0, 3, 32'h1234_5678,
              0, 32'h1234_5678, 4, 5, "ld_done_wins");
      run_req(1, 32'hFFFE_FFFC, 32'h5, 0, 32'h0,
              1, 32'h0, 0, 1, "st_below_win");
      run_req(1, 32'hFFFF_FFFC, 32'hCAFE_F00D, 1, 32'h3333_3333,
              0, 32'h0, 2, 3, "st_top_word");

      // Back-to-back: second request held during the first's BUSY
      @(negedge clk);
      push_exp(0, 32'hA5A5_0001, 32'h0);
      push_exp(0, 32'hA5A5_0002, 32'h0);
      tb_wr = 1'b0;
      exp_addr = 32'hFFFF_0020;
      exp_wdata = 32'h0;
      dev_wait = 1;
      dev_data = 32'hA5A5_0001;
      strobe_cnt = 0;
      stab_bad = 0;
      b.req_valid = 1'b1;
      b.req_write = 1'b0;
      b.req_addr = 32'hFFFF_0020;
      b.req_wdata = 32'h0;
      @(posedge clk);
      #1 b.req_addr = 32'hFFFF_0024;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!b.resp_valid && lat < 300);
      chk("b2b_first_latency", 32'(lat), 32'd3);
      chk("b2b_resp_strobes", {30'd0, b.mmio_read, b.mmio_write}, 32'd0);
      exp_addr = 32'hFFFF_0024;
      dev_data = 32'hA5A5_0002;
      @(negedge clk);
      chk("b2b_gap_ready", 32'(b.req_ready), 32'd1);
      chk("b2b_gap_strobes", {30'd0, b.mmio_read, b.mmio_write}, 32'd0);
      @(negedge clk);
      chk("b2b_second_read", 32'(b.mmio_read), 32'd1);
      chk("b2b_second_addr", b.mmio_addr, 32'hFFFF_0024);
      b.req_valid = 1'b0;
      lat = 0;
      while (!b.resp_valid && lat < 300) begin
         @(negedge clk);
         lat++;
      end
      chk("b2b_second_latency", 32'(lat), 32'd2);
      chk("b2b_strobes", 32'(strobe_cnt), 32'd4);
      chk("b2b_stable", 32'(stab_bad), 32'd0);

      // Asynchronous reset during BUSY of a read
      @(negedge clk);
      tb_wr = 1'b0;
      exp_addr = 32'hFFFF_0200;
      exp_wdata = 32'h0;
      dev_wait = -1;
      b.req_valid = 1'b1;
      b.req_write = 1'b0;
      b.req_addr = 32'hFFFF_0200;
      @(posedge clk);
      #1 b.req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_read", 32'(b.mmio_read), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_read", 32'(b.mmio_read), 32'd0);
      chk("async_rst_addr", b.mmio_addr, 32'h0);
      chk("async_rst_ready", 32'(b.req_ready), 32'd1);
      chk("async_rst_err_addr", b.err_addr, 32'h0);
      chk("async_rst_resp", {31'd0, b.resp_valid}, 32'd0);
      last_err = 32'h0;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("post_rst_no_resp", {31'd0, b.resp_valid}, 32'd0);
      end
      run_req(0, 32'hFFFF_0300, 32'h0, 0, 32'h0BAD_F00D,
              0, 32'h0BAD_F00D, 1, 2, "ld_after_rst");

      repeat (3) @(negedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      chk("never_both_strobes", 32'(both_cnt), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/mmio_bus_ctrl.md
Name: mmio_bus_ctrl

Overview:
- MMIO request controller between the CPU memory stage and the MMIO device aggregator.
- Accepts one load/store request at a time, checks it, and drives mmio_read/mmio_write/mmio_addr/mmio_write_data stable until mmio_done.
- Returns a one-cycle response carrying read data or an error flag; a timeout guards against unmapped or hung devices.
- The memory stage stalls while req_ready is low.

Parameters:
- MMIO_BASE, 32'hFFFF_0000: base of the MMIO window.
- MMIO_MASK, 32'hFFFF_0000: address bits compared against MMIO_BASE.
- TIMEOUT_CYCLES, 255: maximum BUSY cycles without mmio_done before an error response; legal range 1..255.

Ports:
- sys_clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous active-high reset
- req_valid  input  1  CPU request strobe, sampled only when req_ready=1
- req_write  input  1  1=store, 0=load
- req_addr  input  32  byte address
- req_wdata  input  32  store data
- req_ready  output  1  controller idle, can accept a request
- resp_valid  output  1  one-cycle response pulse
- resp_err  output  1  qualifies resp_valid: misaligned, out of window, or timeout
- resp_rdata  output  32  load data, valid with resp_valid
- mmio_read  output  1  read strobe to the device aggregator
- mmio_write  output  1  write strobe to the device aggregator
- mmio_addr  output  32  latched request address
- mmio_write_data  output  32  latched store data
- mmio_done  input  1  device completion, combinational from the aggregator
- mmio_read_data  input  32  device read data, valid when mmio_done=1
- err_addr  output  32  address of the most recent errored request (sticky debug)

Behaviour:
- All outputs are registered, except req_ready, which is decoded from state.
- Reset (asynchronous, any state): state=IDLE; mmio_read=mmio_write=0; mmio_addr=mmio_write_data=0; resp_valid=resp_err=0; resp_rdata=0; err_addr=0; timeout counter=0.
- Reset mid-transaction aborts the transaction with no response.
- FSM states: IDLE, BUSY, RESP. req_ready=(state==IDLE).
- IDLE, req_valid=1:
  - Latch req_addr into mmio_addr and req_wdata into mmio_write_data.
  - If req_addr[1:0]!=0 or (req_addr & MMIO_MASK)!=MMIO_BASE: go to RESP with resp_err=1, resp_rdata=0, err_addr=req_addr. No strobe is ever raised.
  - Otherwise: go to BUSY, set mmio_read=~req_write and mmio_write=req_write, counter=0.
- IDLE, req_valid=0: hold.
- IDLE, mmio_done=1: ignored.
- BUSY: mmio_read, mmio_write, mmio_addr and mmio_write_data stay constant.
  - mmio_done=1 at an edge: clear both strobes, set resp_rdata=mmio_read_data for a read or 0 for a write, resp_err=0, go to RESP.
  - mmio_done=0 and counter==TIMEOUT_CYCLES-1: clear strobes, set resp_err=1, resp_rdata=0, err_addr=mmio_addr, go to RESP.
  - Otherwise: counter+1 (8-bit).
  - mmio_done and timeout in the same cycle: done wins, no error.
- RESP: resp_valid=1 for exactly this one cycle; next state IDLE. resp_valid, resp_err and resp_rdata clear to 0 on leaving RESP.
- Requests are not pipelined. req_valid while req_ready=0 is ignored; the CPU holds it and it is accepted once IDLE.
- Latency:
  - Request accepted at edge E0; strobes high after E0.
  - Zero-wait device: done sampled at E1, resp_valid high after E1, req_ready high after E2. Minimum round trip is 2 cycles accept-to-response, with 1 dead cycle.
  - Error-check rejects: resp_valid after E0.
- Strobes and mmio_read_data are never both high for write.
- mmio_read and mmio_write are never both 1.
- err_addr changes only on an error; it is unaffected by successful transactions.

Test Plan:
- Load from 0xFFFF_0000; device returns done in the first strobe cycle with data 0x00AB_CDEF -> mmio_read high exactly 1 cycle, resp_valid 1 cycle with resp_rdata=0x00AB_CDEF, resp_err=0, 2 cycles after accept.
- Store 0x0000_00FF to 0xFFFF_0010; device delays done by 3 cycles -> mmio_write high 4 cycles, mmio_addr/mmio_write_data stable throughout, resp_rdata=0, resp_err=0.
- Load from 0xFFFF_0002, then from 0x0000_1000 -> no strobe for either, resp_valid the next cycle with resp_err=1; err_addr=0xFFFF_0002, then 0x0000_1000.
- TIMEOUT_CYCLES=4, load from 0xFFFF_0100, mmio_done never asserted -> mmio_read high exactly 4 cycles, then resp_err=1, resp_rdata=0, err_addr=0xFFFF_0100. Repeat with done asserted in the 4th BUSY cycle -> resp_err=0 (done wins).
- Back-to-back: req_valid held high during BUSY with a second address -> second request accepted only after RESP, strobes low for at least 1 cycle between transactions.
- Assert rst during BUSY of a read -> strobes and all outputs at 0 immediately with no clock, no resp_valid pulse; after release, a new load completes normally.
